// File: rtl/control_unit.sv
// control_unit -- multicycle RV64I control sequencer.
//
// Sequences instruction fetch, decode, execute and the optional data-memory
// access and write-back phase of each instruction. It drives every Dataflow
// selector and strobe from the opcode/funct fields and the ALU flags.
//
// Ports:
//   clock, reset (async, active-low)
//   opcode/funct3/funct7          instruction fields from the Dataflow
//   zero/negative/carry_out/overflow  ALU flags (branch resolution)
//   instruction_mem_enable / instruction_mem_busy   fetch handshake
//   data_mem_read_enable / data_mem_write_enable / data_mem_busy   data handshake
//   alua_src, alub_src, aluy_src, alu_src, carry_in, arithmetic   ALU controls
//   alupc_src, pc_src, pc_enable  PC update controls
//   read_data_src, write_register_src, write_register_enable   write-back controls
//   illegal_instruction           sticky flag, set when an undecodable opcode halts the core
//
// Build option: define RV64_WORD_OPS_EN to decode OP-32 / OP-IMM-32
// (aluy_src selects the 32-bit sign-extended result). Without it both
// opcodes are illegal and aluy_src stays 0.

module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       negative,
  input  logic       carry_out,
  input  logic       overflow,
  output logic       instruction_mem_enable,
  input  logic       instruction_mem_busy,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  input  logic       data_mem_busy,
  output logic       alua_src,
  output logic       alub_src,
  output logic       aluy_src,
  output logic [2:0] alu_src,
  output logic       carry_in,
  output logic       arithmetic,
  output logic       alupc_src,
  output logic       pc_src,
  output logic       pc_enable,
  output logic [2:0] read_data_src,
  output logic [1:0] write_register_src,
  output logic       write_register_enable,
  output logic       illegal_instruction
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
`ifdef RV64_WORD_OPS_EN
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXECUTE,
    S_MEM, S_MEM_WAIT, S_WRITEBACK, S_HALT
  } state_t;

  state_t     r_state, w_next;
  logic       r_wait_first;
  logic       r_alua, r_alub, r_aluy, r_cin, r_arith, r_alupc, r_pcsrc;
  logic [2:0] r_alu, r_rds, r_f3;
  logic [1:0] r_wrs;
  logic       r_load, r_store, r_branch, r_illegal;

  logic       w_legal, w_alua, w_alub, w_aluy, w_cin, w_arith, w_alupc, w_pcsrc;
  logic [2:0] w_alu, w_rds;
  logic [1:0] w_wrs;
  logic       w_load, w_store, w_branch;
  logic       w_cond, w_taken;
  logic       w_ime, w_dre, w_dwe, w_pce, w_wre;

  // Opcode decode; only sampled into the selector registers in DECODE.
  always_comb begin
    w_legal  = 1'b1;
    w_alua   = 1'b0;
    w_alub   = 1'b0;
    w_aluy   = 1'b0;
    w_alu    = 3'b000;
    w_cin    = 1'b0;
    w_arith  = 1'b0;
    w_alupc  = 1'b0;
    w_pcsrc  = 1'b0;
    w_rds    = 3'b000;
    w_wrs    = 2'b00;
    w_load   = 1'b0;
    w_store  = 1'b0;
    w_branch = 1'b0;
    case (opcode)
      OPC_OP: begin
        w_alu   = funct3;
        w_arith = funct7;
        w_cin   = funct7 & (funct3 == 3'b000);
      end
      OPC_OP_IMM: begin
        w_alu   = funct3;
        w_alub  = 1'b1;
        // funct7 is an immediate bit except for the shift-right pair
        w_arith = funct7 & (funct3 == 3'b101);
      end
`ifdef RV64_WORD_OPS_EN
      OPC_OP_32: begin
        w_alu   = funct3;
        w_arith = funct7;
        w_cin   = funct7 & (funct3 == 3'b000);
        w_aluy  = 1'b1;
      end
      OPC_OP_IMM_32: begin
        w_alu   = funct3;
        w_alub  = 1'b1;
        w_arith = funct7 & (funct3 == 3'b101);
        w_aluy  = 1'b1;
      end
`endif
      OPC_LUI:   w_wrs = 2'b11;
      OPC_AUIPC: begin
        w_alua = 1'b1;
        w_alub = 1'b1;
      end
      OPC_JAL: begin
        w_wrs   = 2'b10;
        w_pcsrc = 1'b1;
      end
      OPC_JALR: begin
        w_alub  = 1'b1;
        w_wrs   = 2'b10;
        w_pcsrc = 1'b1;
        w_alupc = 1'b1;
      end
      OPC_LOAD: begin
        w_alub = 1'b1;
        w_rds  = funct3;
        w_wrs  = 2'b01;
        w_load = 1'b1;
      end
      OPC_STORE: begin
        w_alub  = 1'b1;
        w_store = 1'b1;
      end
      OPC_BRANCH: begin
        w_cin    = 1'b1;
        w_branch = 1'b1;
        w_legal  = (funct3[2:1] != 2'b01);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Branch resolution from the subtract flags of the comparison.
  always_comb begin
    case (r_f3[2:1])
      2'b00:   w_cond = zero;
      2'b10:   w_cond = negative ^ overflow;
      2'b11:   w_cond = carry_out;
      default: w_cond = 1'b0;
    endcase
    w_taken = w_cond ^ r_f3[0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait_first <= 1'b0;
    end else begin
      r_state      <= w_next;
      // The memory cannot report busy in the cycle after the request.
      r_wait_first <= (r_state == S_FETCH) || (r_state == S_MEM);
    end
  end

  always_comb begin
    w_next = r_state;
    w_ime  = 1'b0;
    w_dre  = 1'b0;
    w_dwe  = 1'b0;
    w_pce  = 1'b0;
    w_wre  = 1'b0;
    case (r_state)
      S_IDLE:       w_next = S_FETCH;
      S_FETCH: begin
        w_ime  = 1'b1;
        w_next = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: if (!r_wait_first && !instruction_mem_busy) w_next = S_DECODE;
      S_DECODE:     w_next = w_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: begin
        if (r_load || r_store) begin
          w_next = S_MEM;
        end else begin
          w_pce  = 1'b1;
          w_wre  = !r_branch;
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        w_dre  = r_load;
        w_dwe  = r_store;
        w_next = S_MEM_WAIT;
      end
      S_MEM_WAIT:   if (!r_wait_first && !data_mem_busy) w_next = S_WRITEBACK;
      S_WRITEBACK: begin
        w_pce  = 1'b1;
        w_wre  = r_load;
        w_next = S_FETCH;
      end
      S_HALT:       w_next = S_HALT;
      default:      w_next = S_IDLE;
    endcase
  end

  // Selector registers: loaded once per instruction, held until next DECODE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alua    <= 1'b0;
      r_alub    <= 1'b0;
      r_aluy    <= 1'b0;
      r_alu     <= 3'b000;
      r_cin     <= 1'b0;
      r_arith   <= 1'b0;
      r_alupc   <= 1'b0;
      r_pcsrc   <= 1'b0;
      r_rds     <= 3'b000;
      r_wrs     <= 2'b00;
      r_f3      <= 3'b000;
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_alua    <= w_alua;
      r_alub    <= w_alub;
      r_aluy    <= w_aluy;
      r_alu     <= w_alu;
      r_cin     <= w_cin;
      r_arith   <= w_arith;
      r_alupc   <= w_alupc;
      r_pcsrc   <= w_pcsrc;
      r_rds     <= w_rds;
      r_wrs     <= w_wrs;
      r_f3      <= funct3;
      r_load    <= w_load;
      r_store   <= w_store;
      r_branch  <= w_branch;
      r_illegal <= r_illegal | !w_legal;
    end
  end

  assign instruction_mem_enable = w_ime;
  assign data_mem_read_enable   = w_dre;
  assign data_mem_write_enable  = w_dwe;
  assign pc_enable              = w_pce;
  assign write_register_enable  = w_wre;
  assign alua_src               = r_alua;
  assign alub_src               = r_alub;
  assign aluy_src               = r_aluy;
  assign alu_src                = r_alu;
  assign carry_in               = r_cin;
  assign arithmetic             = r_arith;
  assign alupc_src              = r_alupc;
  // Branches resolve live from the flags while in EXECUTE.
  assign pc_src                 = r_branch ? ((r_state == S_EXECUTE) && w_taken) : r_pcsrc;
  assign read_data_src          = r_rds;
  assign write_register_src     = r_wrs;
  assign illegal_instruction    = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7 = 1'b0;
  logic       zero = 1'b0, negative = 1'b0, carry_out = 1'b0, overflow = 1'b0;
  logic       instruction_mem_busy = 1'b0, data_mem_busy = 1'b0;
  logic       instruction_mem_enable, data_mem_read_enable, data_mem_write_enable;
  logic       alua_src, alub_src, aluy_src, carry_in, arithmetic, alupc_src, pc_src, pc_enable;
  logic [2:0] alu_src, read_data_src;
  logic [1:0] write_register_src;
  logic       write_register_enable, illegal_instruction;

  control_unit dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
    .instruction_mem_enable(instruction_mem_enable), .instruction_mem_busy(instruction_mem_busy),
    .data_mem_read_enable(data_mem_read_enable), .data_mem_write_enable(data_mem_write_enable),
    .data_mem_busy(data_mem_busy), .alua_src(alua_src), .alub_src(alub_src), .aluy_src(aluy_src),
    .alu_src(alu_src), .carry_in(carry_in), .arithmetic(arithmetic), .alupc_src(alupc_src),
    .pc_src(pc_src), .pc_enable(pc_enable), .read_data_src(read_data_src),
    .write_register_src(write_register_src), .write_register_enable(write_register_enable),
    .illegal_instruction(illegal_instruction)
  );

  always #5 clock = ~clock;

  wire [20:0] all_out = {instruction_mem_enable, data_mem_read_enable, data_mem_write_enable,
                         alua_src, alub_src, aluy_src, alu_src, carry_in, arithmetic, alupc_src,
                         pc_src, pc_enable, read_data_src, write_register_src,
                         write_register_enable, illegal_instruction};

  // {alua,alub,aluy} alu {cin,arith,alupc,pcsrc} rds wrs wre
  typedef logic [15:0] sel_t;
  typedef struct packed {
    sel_t       sel;
    logic [7:0] n_ime, n_dre, n_dwe, n_wre, n_pce, cyc, mcyc, lead;
    logic       overlap, illegal, done;
  } obs_t;
  typedef struct packed { sel_t sel; logic [7:0] cyc; logic [7:0] mcyc; } exp_t;
  typedef struct packed { logic [6:0] op; logic [2:0] f3; logic f7; logic [3:0] ki; sel_t sel; } vec_t;
  typedef struct packed { logic [2:0] f3; logic [3:0] flg; logic taken; } br_t;

  exp_t q_exp[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic sel_t mk_sel(input logic [2:0] srcs, input logic [2:0] alu,
                                  input logic [3:0] ctl, input logic [2:0] rds,
                                  input logic [1:0] wrs, input logic wre);
    return {srcs, alu, ctl, rds, wrs, wre};
  endfunction

  // Wait-state length for a memory that holds busy for k cycles after the request:
  // the first wait cycle never exits, later ones exit on busy low.
  function automatic int wait_len(input int k);
    return (k < 1) ? 2 : k + 1;
  endfunction

  // Drives one instruction and records what the DUT does until pc_enable or budget.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] flg, input int ki, input int kd,
                           input int budget, output obs_t o);
    int icnt, dcnt;
    bit started, mstarted;
    o = '0; icnt = 0; dcnt = 0; started = 0; mstarted = 0;
    opcode = op; funct3 = f3; funct7 = f7;
    {zero, negative, carry_out, overflow} = flg;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (instruction_mem_enable) begin
        started = 1; icnt = ki; instruction_mem_busy = 1'b1;
      end else begin
        instruction_mem_busy = (icnt > 0);
        if (icnt > 0) icnt--;
      end
      if (data_mem_read_enable || data_mem_write_enable) begin
        mstarted = 1; dcnt = kd; data_mem_busy = 1'b1;
      end else begin
        data_mem_busy = (dcnt > 0);
        if (dcnt > 0) dcnt--;
      end
      if (!started) o.lead = o.lead + 8'd1;
      else          o.cyc  = o.cyc + 8'd1;
      if (mstarted) o.mcyc = o.mcyc + 8'd1;
      o.n_ime = o.n_ime + 8'(instruction_mem_enable);
      o.n_dre = o.n_dre + 8'(data_mem_read_enable);
      o.n_dwe = o.n_dwe + 8'(data_mem_write_enable);
      o.n_wre = o.n_wre + 8'(write_register_enable);
      o.n_pce = o.n_pce + 8'(pc_enable);
      if (int'(instruction_mem_enable) + int'(data_mem_read_enable) + int'(data_mem_write_enable) > 1)
        o.overlap = 1'b1;
      o.illegal = illegal_instruction;
      if (pc_enable) begin
        o.sel = {alua_src, alub_src, aluy_src, alu_src, carry_in, arithmetic, alupc_src,
                 pc_src, read_data_src, write_register_src, write_register_enable};
        o.done = 1'b1;
        break;
      end
    end
    instruction_mem_busy = 1'b0;
    data_mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    n_total++;
    if (all_out !== 21'd0) $display("FAIL reset_async: outputs=%h expected=%h", all_out, 21'd0);
    else n_pass++;
    repeat (3) @(negedge clock);
    n_total++;
    if (all_out !== 21'd0) $display("FAIL reset_held: outputs=%h expected=%h", all_out, 21'd0);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_addi();
    obs_t o; exp_t e;
    q_exp.push_back('{sel: mk_sel(3'b010, 3'b000, 4'b0000, 3'b000, 2'b00, 1'b1),
                      cyc: 8'(3 + wait_len(12)), mcyc: 8'd0});
    run_instr(7'b0010011, 3'b000, 1'b0, 4'b0000, 12, 0, 100, o);
    e = q_exp.pop_front();
    n_total++;
    if (o.sel !== e.sel) $display("FAIL addi_sel: got=%h expected=%h", o.sel, e.sel);
    else n_pass++;
    n_total++;
    if (o.cyc !== e.cyc) $display("FAIL addi_cycles: got=%0d expected=%0d", o.cyc, e.cyc);
    else n_pass++;
    n_total++;
    if ({o.done, o.lead, o.n_ime, o.n_wre, o.n_pce} !== {1'b1, 8'd0, 8'd1, 8'd1, 8'd1})
      $display("FAIL addi_strobes: done=%0d lead=%0d ime=%0d wre=%0d pce=%0d expected 1/0/1/1/1",
               o.done, o.lead, o.n_ime, o.n_wre, o.n_pce);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    vec_t tbl [10];
    obs_t o; exp_t e;
    tbl[0] = {7'b0110011, 3'b000, 1'b0, 4'd0, mk_sel(3'b000, 3'b000, 4'b0000, 3'b000, 2'b00, 1'b1)}; // ADD
    tbl[1] = {7'b0110011, 3'b000, 1'b1, 4'd3, mk_sel(3'b000, 3'b000, 4'b1100, 3'b000, 2'b00, 1'b1)}; // SUB
    tbl[2] = {7'b0110011, 3'b101, 1'b1, 4'd1, mk_sel(3'b000, 3'b101, 4'b0100, 3'b000, 2'b00, 1'b1)}; // SRA
    tbl[3] = {7'b0010011, 3'b101, 1'b1, 4'd2, mk_sel(3'b010, 3'b101, 4'b0100, 3'b000, 2'b00, 1'b1)}; // SRAI
    tbl[4] = {7'b0010011, 3'b100, 1'b1, 4'd0, mk_sel(3'b010, 3'b100, 4'b0000, 3'b000, 2'b00, 1'b1)}; // XORI
    tbl[5] = {7'b0110011, 3'b011, 1'b0, 4'd4, mk_sel(3'b000, 3'b011, 4'b0000, 3'b000, 2'b00, 1'b1)}; // SLTU
    tbl[6] = {7'b0110111, 3'b000, 1'b0, 4'd0, mk_sel(3'b000, 3'b000, 4'b0000, 3'b000, 2'b11, 1'b1)}; // LUI
    tbl[7] = {7'b0010111, 3'b000, 1'b0, 4'd1, mk_sel(3'b110, 3'b000, 4'b0000, 3'b000, 2'b00, 1'b1)}; // AUIPC
    tbl[8] = {7'b1101111, 3'b000, 1'b0, 4'd2, mk_sel(3'b000, 3'b000, 4'b0001, 3'b000, 2'b10, 1'b1)}; // JAL
    tbl[9] = {7'b1100111, 3'b000, 1'b0, 4'd0, mk_sel(3'b010, 3'b000, 4'b0011, 3'b000, 2'b10, 1'b1)}; // JALR
    for (int i = 0; i < 10; i++)
      q_exp.push_back('{sel: tbl[i].sel, cyc: 8'(3 + wait_len(int'(tbl[i].ki))), mcyc: 8'd0});
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, 4'b0000, int'(tbl[i].ki), 0, 100, o);
      e = q_exp.pop_front();
      n_total++;
      if (o.sel !== e.sel) $display("FAIL b2b_sel[%0d]: got=%h expected=%h", i, o.sel, e.sel);
      else n_pass++;
      n_total++;
      if (o.cyc !== e.cyc) $display("FAIL b2b_cycles[%0d]: got=%0d expected=%0d", i, o.cyc, e.cyc);
      else n_pass++;
      n_total++;
      if ({o.done, o.lead, o.n_ime, o.n_wre, o.n_dre, o.n_dwe, o.overlap} !==
          {1'b1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 1'b0})
        $display("FAIL b2b_strobes[%0d]: done=%0d lead=%0d ime=%0d wre=%0d dre=%0d dwe=%0d ovl=%0d expected 1/0/1/1/0/0/0",
                 i, o.done, o.lead, o.n_ime, o.n_wre, o.n_dre, o.n_dwe, o.overlap);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    br_t  br [8];
    obs_t o; exp_t e;
    // flg = {zero, negative, carry_out, overflow}
    br[0] = {3'b000, 4'b1000, 1'b1}; // BEQ  equal
    br[1] = {3'b000, 4'b0000, 1'b0}; // BEQ  not equal
    br[2] = {3'b001, 4'b1000, 1'b0}; // BNE  equal
    br[3] = {3'b100, 4'b0100, 1'b1}; // BLT  neg, no ovf
    br[4] = {3'b100, 4'b0001, 1'b1}; // BLT  ovf only
    br[5] = {3'b101, 4'b0101, 1'b1}; // BGE  neg^ovf = 0
    br[6] = {3'b110, 4'b0010, 1'b1}; // BLTU borrow
    br[7] = {3'b111, 4'b0010, 1'b0}; // BGEU borrow
    for (int i = 0; i < 8; i++)
      q_exp.push_back('{sel: mk_sel(3'b000, 3'b000, {3'b100, br[i].taken}, 3'b000, 2'b00, 1'b0),
                        cyc: 8'(3 + wait_len(i % 3)), mcyc: 8'd0});
    for (int i = 0; i < 8; i++) begin
      run_instr(7'b1100011, br[i].f3, 1'b0, br[i].flg, i % 3, 0, 100, o);
      e = q_exp.pop_front();
      n_total++;
      if (o.sel !== e.sel) $display("FAIL branch_sel[%0d]: got=%h expected=%h", i, o.sel, e.sel);
      else n_pass++;
      n_total++;
      if ({o.done, o.n_wre, o.cyc} !== {1'b1, 8'd0, e.cyc})
        $display("FAIL branch_timing[%0d]: done=%0d wre=%0d cycles=%0d expected 1/0/%0d",
                 i, o.done, o.n_wre, o.cyc, e.cyc);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    obs_t o; exp_t e;
    q_exp.push_back('{sel: mk_sel(3'b010, 3'b000, 4'b0000, 3'b011, 2'b01, 1'b1),
                      cyc: 8'd0, mcyc: 8'(2 + wait_len(5))});
    q_exp.push_back('{sel: mk_sel(3'b010, 3'b000, 4'b0000, 3'b100, 2'b01, 1'b1),
                      cyc: 8'd0, mcyc: 8'(2 + wait_len(0))});
    run_instr(7'b0000011, 3'b011, 1'b0, 4'b0000, 2, 5, 100, o);   // LD
    e = q_exp.pop_front();
    n_total++;
    if (o.sel !== e.sel) $display("FAIL ld_sel: got=%h expected=%h", o.sel, e.sel);
    else n_pass++;
    n_total++;
    if ({o.done, o.mcyc, o.n_ime, o.n_dre, o.n_dwe, o.n_wre, o.n_pce, o.overlap} !==
        {1'b1, e.mcyc, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0})
      $display("FAIL ld_strobes: done=%0d memcyc=%0d ime=%0d dre=%0d dwe=%0d wre=%0d pce=%0d ovl=%0d expected 1/%0d/1/1/0/1/1/0",
               o.done, o.mcyc, o.n_ime, o.n_dre, o.n_dwe, o.n_wre, o.n_pce, o.overlap, e.mcyc);
    else n_pass++;
    run_instr(7'b0000011, 3'b100, 1'b0, 4'b0000, 0, 0, 100, o);   // LBU
    e = q_exp.pop_front();
    n_total++;
    if ({o.sel, o.mcyc, o.n_dre} !== {e.sel, e.mcyc, 8'd1})
      $display("FAIL lbu: sel=%h memcyc=%0d dre=%0d expected %h/%0d/1", o.sel, o.mcyc, o.n_dre, e.sel, e.mcyc);
    else n_pass++;
  endtask

  task automatic test_store();
    obs_t o; exp_t e;
    q_exp.push_back('{sel: mk_sel(3'b010, 3'b000, 4'b0000, 3'b000, 2'b00, 1'b0),
                      cyc: 8'd0, mcyc: 8'(2 + wait_len(1))});
    run_instr(7'b0100011, 3'b011, 1'b0, 4'b0000, 1, 1, 100, o);   // SD
    e = q_exp.pop_front();
    n_total++;
    if (o.sel !== e.sel) $display("FAIL sd_sel: got=%h expected=%h", o.sel, e.sel);
    else n_pass++;
    n_total++;
    if ({o.done, o.mcyc, o.n_dre, o.n_dwe, o.n_wre, o.overlap} !== {1'b1, e.mcyc, 8'd0, 8'd1, 8'd0, 1'b0})
      $display("FAIL sd_strobes: done=%0d memcyc=%0d dre=%0d dwe=%0d wre=%0d ovl=%0d expected 1/%0d/0/1/0/0",
               o.done, o.mcyc, o.n_dre, o.n_dwe, o.n_wre, o.overlap, e.mcyc);
    else n_pass++;
  endtask

  task automatic test_reset_midfetch();
    obs_t o;
    opcode = 7'b0010011; funct3 = 3'b000; funct7 = 1'b0;
    @(negedge clock);
    n_total++;
    if (instruction_mem_enable !== 1'b1)
      $display("FAIL midfetch_fetch: instruction_mem_enable=%b expected=1", instruction_mem_enable);
    else n_pass++;
    instruction_mem_busy = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (all_out !== 21'd0) $display("FAIL midfetch_reset: outputs=%h expected=%h", all_out, 21'd0);
    else n_pass++;
    repeat (2) @(negedge clock);
    n_total++;
    if (all_out !== 21'd0) $display("FAIL midfetch_hold: outputs=%h expected=%h", all_out, 21'd0);
    else n_pass++;
    reset = 1'b1;
    instruction_mem_busy = 1'b0;
    run_instr(7'b0010011, 3'b000, 1'b0, 4'b0000, 0, 0, 100, o);
    n_total++;
    if ({o.done, o.lead, o.cyc, o.n_ime} !== {1'b1, 8'd0, 8'(3 + wait_len(0)), 8'd1})
      $display("FAIL midfetch_restart: done=%0d lead=%0d cycles=%0d ime=%0d expected 1/0/%0d/1",
               o.done, o.lead, o.cyc, o.n_ime, 3 + wait_len(0));
    else n_pass++;
  endtask

  task automatic test_illegal();
    obs_t o;
    run_instr(7'b1111111, 3'b000, 1'b0, 4'b0000, 0, 0, 20, o);
    n_total++;
    if ({o.done, o.illegal, o.n_ime, o.n_dre, o.n_dwe, o.n_wre, o.n_pce} !==
        {1'b0, 1'b1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0})
      $display("FAIL illegal_halt: done=%0d illegal=%0d ime=%0d dre=%0d dwe=%0d wre=%0d pce=%0d expected 0/1/1/0/0/0/0",
               o.done, o.illegal, o.n_ime, o.n_dre, o.n_dwe, o.n_wre, o.n_pce);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({illegal_instruction, all_out} !== 22'd0)
      $display("FAIL illegal_cleared: illegal=%b outputs=%h expected 0/0", illegal_instruction, all_out);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_word_ops();
    obs_t o;
    run_instr(7'b0011011, 3'b000, 1'b0, 4'b0000, 0, 0, 20, o);    // ADDIW
`ifdef RV64_WORD_OPS_EN
    n_total++;
    if ({o.done, o.sel} !== {1'b1, mk_sel(3'b011, 3'b000, 4'b0000, 3'b000, 2'b00, 1'b1)})
      $display("FAIL addiw: done=%0d sel=%h expected 1/%h", o.done, o.sel,
               mk_sel(3'b011, 3'b000, 4'b0000, 3'b000, 2'b00, 1'b1));
    else n_pass++;
`else
    n_total++;
    if ({o.done, o.illegal, o.n_ime, o.n_wre, o.n_pce, o.n_dre, o.n_dwe} !==
        {1'b0, 1'b1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0})
      $display("FAIL addiw_illegal: done=%0d illegal=%0d ime=%0d wre=%0d pce=%0d dre=%0d dwe=%0d expected 0/1/1/0/0/0/0",
               o.done, o.illegal, o.n_ime, o.n_wre, o.n_pce, o.n_dre, o.n_dwe);
    else n_pass++;
    n_total++;
    if (aluy_src !== 1'b0) $display("FAIL addiw_aluy: got=%b expected=0", aluy_src);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch();
    test_load();
    test_store();
    test_reset_midfetch();
    test_illegal();
    test_word_ops();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
